// File: rtl/paddle_controller.sv
// One player's paddle: button synchronisers and debouncers, a four-state direction FSM,
// and a clamped, accelerating position register stepped on move_tick.
module paddle_controller #(
  parameter int PADDLE_HEIGHT   = 60,
  parameter int TOP_LIMIT       = 0,
  parameter int BOTTOM_LIMIT    = 480,
  parameter int STEP            = 4,
  parameter int FAST_STEP       = 8,
  parameter int ACCEL_TICKS     = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       move_tick,
  input  logic       recenter,
  output logic [9:0] paddle_loc,
  output logic       moving_up,
  output logic       moving_down
);

  localparam logic [9:0]  CENTER    = 10'((TOP_LIMIT + BOTTOM_LIMIT - PADDLE_HEIGHT) / 2);
  localparam logic [10:0] MIN_LOC   = 11'(TOP_LIMIT);
  localparam logic [10:0] MAX_LOC   = 11'(BOTTOM_LIMIT - PADDLE_HEIGHT);
  localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]  ACCEL_THR = 5'(ACCEL_TICKS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Bit 0 carries the up button, bit 1 the down button, throughout.
  logic [1:0]       btn_raw;
  logic [1:0]       s1_q, s2_q;
  logic [1:0]       db_q, db_d;
  logic [1:0][19:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic [3:0]       accel_q, accel_d;
  logic [9:0]       loc_q, loc_d;
  logic [9:0]       step;

  assign btn_raw = {btn_down, btn_up};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        db_d[i]  = ~db_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 20'd1;
      end
    end
  end

  always_comb begin
    case (db_q)
      2'b01:   state_d = ST_UP;
      2'b10:   state_d = ST_DOWN;
      2'b11:   state_d = ST_HOLD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moves use the state and accel count held before this edge; bounds are checked at 11 bits.
  always_comb begin
    step    = ({1'b0, accel_q} >= ACCEL_THR) ? 10'(FAST_STEP) : 10'(STEP);
    loc_d   = loc_q;
    accel_d = accel_q;
    if (recenter) begin
      loc_d   = CENTER;
      accel_d = '0;
    end else if (move_tick && (state_q == ST_UP || state_q == ST_DOWN)) begin
      if (state_q == ST_UP) begin
        loc_d = ({1'b0, loc_q} < MIN_LOC + {1'b0, step}) ? MIN_LOC[9:0] : loc_q - step;
      end else begin
        loc_d = ({1'b0, loc_q} + {1'b0, step} > MAX_LOC) ? MAX_LOC[9:0] : loc_q + step;
      end
      if (accel_q != 4'hF) accel_d = accel_q + 4'd1;
    end
    if (state_d != state_q) accel_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q    <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      accel_q <= '0;
      loc_q   <= CENTER;
    end else begin
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      accel_q <= accel_d;
      loc_q   <= loc_d;
    end
  end

  assign paddle_loc  = loc_q;
  assign moving_up   = (state_q == ST_UP);
  assign moving_down = (state_q == ST_DOWN);

endmodule
